// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-source round-robin arbiter.
package arb_pkg;

    typedef logic [1:0] sel_t;

    localparam int unsigned N_SRC     = 4;
    localparam sel_t        SEL_RESET = 2'd3;

    function automatic logic [N_SRC-1:0] onehot(input sel_t idx);
        logic [N_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_4_1_w.sv
// Width-parametrised 4:1 case mux feeding the arbiter output register.
module mux_4_1_w
    import arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  sel_t         sel,
    output logic [W-1:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/rr_arb_4_1.sv
// Four-source round-robin stream arbiter with a registered valid/ready output
// carrying both the selected word and its source index.
module rr_arb_4_1
    import arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] in_valid,
    output logic [N_SRC-1:0] in_ready,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output sel_t             out_sel
);

    sel_t         last;
    sel_t         g;
    logic         grant_vld;
    logic         load;
    logic [W-1:0] mux_y;

    assign load = !out_valid || out_ready;

    // Search starts just after the last winner; offset N_SRC wraps back to last itself.
    always_comb begin
        sel_t cand;
        g         = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            cand = last + sel_t'(k);
            if (!grant_vld && in_valid[cand]) begin
                g         = cand;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst && load && grant_vld)
            in_ready = onehot(g);
    end

    mux_4_1_w #(.W(W)) u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .sel (g),
        .y   (mux_y)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            last      <= SEL_RESET;
        end else if (load) begin
            if (grant_vld) begin
                out_valid <= 1'b1;
                out_data  <= mux_y;
                out_sel   <= g;
                last      <= g;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
